// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: splits a shift amount into greedy 8/2/1 steps
// executed on a shift-by-constant ALU, feeding the ALU result back each cycle.
module shift_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  operand,
  input  logic               abort,
  input  logic [DATA_W-1:0]  alu_result,
  output logic [5:0]         alu_ctrl,
  output logic [DATA_W-1:0]  alu_a,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  acc;
  logic [SHAMT_W-1:0] rem;
  logic [SHAMT_W-1:0] step;
  logic [SHAMT_W-1:0] rem_next;
  logic [1:0]         op_q;
  logic [1:0]         sel;

  // sel indexes the 1/2/8 code within each op's group of three ALU codes
  always_comb begin
    sel  = 2'd0;
    step = SHAMT_W'(1);
    if (rem >= SHAMT_W'(8)) begin
      sel  = 2'd2;
      step = SHAMT_W'(8);
    end else if (rem >= SHAMT_W'(2)) begin
      sel  = 2'd1;
      step = SHAMT_W'(2);
    end
    rem_next = rem - step;
  end

  // Outside SHIFT the ALU is parked on code 0 with a zero operand
  always_comb begin
    alu_ctrl = '0;
    alu_a    = '0;
    if (state == SHIFT) begin
      alu_a = acc;
      case (op_q)
        2'd0:    alu_ctrl = 6'h0A + 6'(sel);
        2'd1:    alu_ctrl = 6'h0D + 6'(sel);
        2'd2:    alu_ctrl = 6'h10 + 6'(sel);
        default: alu_ctrl = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      op_q   <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            acc  <= operand;
            rem  <= shamt;
            op_q <= op;
            busy <= 1'b1;
            if (shamt == '0 || op == 2'd3) begin
              state  <= DONE;
              result <= operand;
              done   <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= alu_result;
            rem <= rem_next;
            if (rem_next == '0) begin
              state  <= DONE;
              result <= alu_result;
              done   <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural shift ALU and
// queue-based scoreboard of expected ALU codes and final results.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] operand;
  logic        abort;
  logic [31:0] alu_result;
  logic [5:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [5:0]  code_q[$];
  logic [31:0] res_q[$];

  shift_sequencer #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .shamt(shamt),
    .operand(operand), .abort(abort), .alu_result(alu_result),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .busy(busy), .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [5:0] c, input logic [31:0] a);
    case (c)
      6'h0A:   return a << 1;
      6'h0B:   return a << 2;
      6'h0C:   return a << 8;
      6'h0D:   return a >> 1;
      6'h0E:   return a >> 2;
      6'h0F:   return a >> 8;
      6'h10:   return $unsigned($signed(a) >>> 1);
      6'h11:   return $unsigned($signed(a) >>> 2);
      6'h12:   return $unsigned($signed(a) >>> 8);
      default: return a & 32'h0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_ctrl, alu_a);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in the cycle where start is driven; returns in cycle N+2.
  task automatic run_job(input string tag, input logic [1:0] o, input logic [4:0] s,
                         input logic [31:0] v, input int exp_n, input logic [31:0] exp_res,
                         input logic repulse);
    int          n;
    bit          got_done;
    logic [31:0] acc_exp;
    logic [5:0]  exp_code;
    check({tag, "_idle_before"}, {31'b0, busy}, 32'd0);
    start = 1'b1; op = o; shamt = s; operand = v;
    res_q.push_back(exp_res);
    acc_exp  = v;
    n        = 0;
    got_done = 0;
    tick();
    start = repulse;
    for (int c = 1; c <= 12 && !got_done; c++) begin
      if (c == 2) start = 1'b0;
      if (alu_ctrl != 6'h00) begin
        n++;
        exp_code = (code_q.size() != 0) ? code_q.pop_front() : 6'h00;
        check({tag, "_code"}, {26'b0, alu_ctrl}, {26'b0, exp_code});
        check({tag, "_alu_a"}, alu_a, acc_exp);
        check({tag, "_busy_shift"}, {31'b0, busy}, 32'd1);
        acc_exp = alu_fn(exp_code, acc_exp);
      end
      if (done) begin
        got_done = 1;
        check({tag, "_done_cycle"}, c, exp_n + 1);
        check({tag, "_result"}, result, res_q.pop_front());
        check({tag, "_park"}, {alu_a[25:0], alu_ctrl}, 32'd0);
      end else begin
        tick();
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'b0, got_done}, 32'd1);
    check({tag, "_steps"}, n, exp_n);
    tick();
    check({tag, "_busy_after"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; shamt = '0; operand = '0; abort = 1'b0;
    tick();
    tick();
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_alu", {alu_a[25:0], alu_ctrl}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: SLL 1 by 31
    code_q = '{6'h0C, 6'h0C, 6'h0C, 6'h0B, 6'h0B, 6'h0B, 6'h0A};
    run_job("sll31", 2'd0, 5'd31, 32'h0000_0001, 7, 32'h0000_0001 << 31, 1'b0);
    check("sll31_codes_left", code_q.size(), 0);

    // 2: SRA 0x80000000 by 10
    code_q = '{6'h12, 6'h11};
    run_job("sra10", 2'd2, 5'd10, 32'h8000_0000, 2, $unsigned($signed(32'h8000_0000) >>> 10), 1'b0);

    // 3: SRL by 0 completes without touching the ALU
    code_q.delete();
    run_job("srl0", 2'd1, 5'd0, 32'hF000_0000, 0, 32'hF000_0000, 1'b0);

    // Reserved op completes immediately with the operand unchanged
    run_job("op3", 2'd3, 5'd17, 32'h1234_5678, 0, 32'h1234_5678, 1'b0);

    // 4: SRL by 3 with start re-pulsed while busy
    code_q = '{6'h0E, 6'h0D};
    run_job("srl3", 2'd1, 5'd3, 32'h8000_0000, 2, 32'h8000_0000 >> 3, 1'b1);
    tick();
    check("srl3_no_requeue", {30'b0, busy, done}, 32'd0);
    check("srl3_result_hold", result, 32'h1000_0000);

    // 5: abort mid-shift
    start = 1'b1; op = 2'd0; shamt = 5'd20; operand = 32'h0000_00FF;
    tick();
    start = 1'b0;
    check("abort_busy_c1", {30'b0, busy, done}, 32'd2);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_c3", {30'b0, busy, done}, 32'd0);
    check("abort_result", result, 32'h1000_0000);
    check("abort_alu", {alu_a[25:0], alu_ctrl}, 32'd0);
    code_q = '{6'h0B, 6'h0B, 6'h0A};
    run_job("after_abort", 2'd0, 5'd5, 32'h0000_0003, 3, 32'h0000_0003 << 5, 1'b0);

    // Abort in IDLE drops a simultaneous start
    start = 1'b1; abort = 1'b1; op = 2'd0; shamt = 5'd4; operand = 32'h1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_idle_start", {30'b0, busy, done}, 32'd0);
    check("abort_idle_result", result, 32'h0000_0060);

    // 6: synchronous reset mid-job
    start = 1'b1; op = 2'd2; shamt = 5'd9; operand = 32'h8000_0000;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", {30'b0, busy, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_alu", {26'b0, alu_ctrl}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
